mix_columns_seq: RTL and testbench

Sequencer for AES (Inv)MixColumns on a full 128-bit state using a single shared GF(2^8) multiplier (PolyMult, field polynomial 0x11B). It steps through all 64 coefficient×byte products, one product per clock, and XOR-accumulates them into the result state. It is the low-area alternative to the fully parallel MixColumns and sits between the ShiftRows and AddRoundKey stages of the round controller.

---
 rtl/mix_columns_seq_pkg.sv | 22 ++
 rtl/mix_columns_seq_if.sv | 15 +
 rtl/mix_columns_seq_poly_mult.sv | 23 ++
 rtl/mix_columns_seq.sv | 112 +++++++++++
 tb/tb_mix_columns_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_seq_pkg.sv
// Shared AES definitions: sequencer state encoding, MixColumns coefficients, byte indexing.
package aes_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 128;
  localparam int unsigned CNT_W   = 6;

  typedef logic [1:0] mc_state_t;
  localparam mc_state_t ST_IDLE = 2'd0;
  localparam mc_state_t ST_MAC  = 2'd1;
  localparam mc_state_t ST_DONE = 2'd2;

  // Circulant first rows of the forward and inverse MixColumns matrices.
  localparam logic [7:0] MC_COEF  [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] IMC_COEF [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

  // Column-major byte index within the 128-bit state: row + 4*col.
  function automatic logic [3:0] byte_idx(input logic [1:0] row, input logic [1:0] col);
    return 4'({col, row});
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Request/result bundle between the round controller and the MixColumns sequencer.
interface mix_columns_seq_if;
  logic         start;
  logic         inverse;
  logic         clear;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;

  modport master (output start, inverse, clear, state_in,
                  input  busy, done, state_out);
  modport slave  (input  start, inverse, clear, state_in,
                  output busy, done, state_out);
endinterface

// File: rtl/mix_columns_seq_poly_mult.sv
// Combinational GF(2^8) multiplier, field polynomial x^8+x^4+x^3+x+1 (0x11B).
module poly_mult (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p_c
);

  logic [7:0] acc_c;
  logic [7:0] sh_c;

  // Shift-and-add: accumulate a*x^i for each set bit of b, reducing on each shift.
  always_comb begin
    acc_c = 8'h00;
    sh_c  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc_c = acc_c ^ sh_c;
      sh_c = {sh_c[6:0], 1'b0} ^ (sh_c[7] ? 8'h1B : 8'h00);
    end
  end

  assign p_c = acc_c;

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential (Inv)MixColumns: 64 coefficient x byte products through one shared multiplier.
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mix_columns_seq_if.slave  bus
);

  mc_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  acc_q, acc_d;
  logic [STATE_W-1:0] src_q, src_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic               inv_q, inv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [1:0]         col, row, term;
  logic [1:0]         coef_sel;
  logic [6:0]         a_lsb, r_lsb;
  logic [BYTE_W-1:0]  a_byte, coef, prod;

  // Operand selection from the counter: a = src(term,col), b = coef[(term-row) mod 4].
  always_comb begin
    col      = cnt_q[5:4];
    row      = cnt_q[3:2];
    term     = cnt_q[1:0];
    coef_sel = 2'(term - row);
    a_lsb    = {4'(4'd15 - byte_idx(term, col)), 3'b000};
    r_lsb    = {4'(4'd15 - byte_idx(row, col)), 3'b000};
    a_byte   = src_q[a_lsb +: 8];
    coef     = inv_q ? IMC_COEF[coef_sel] : MC_COEF[coef_sel];
  end

  poly_mult u_poly_mult (
    .a   (a_byte),
    .b   (coef),
    .p_c (prod)
  );

  // Next-state and datapath update; clear overrides everything and suppresses the result write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    src_d   = src_q;
    inv_d   = inv_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_d   = bus.state_in;
          inv_d   = bus.inverse;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (term == 2'd3) begin
          out_d[r_lsb +: 8] = acc_q ^ prod;
          acc_d             = '0;
        end else begin
          acc_d = acc_q ^ prod;
        end
        if (cnt_q == CNT_W'(63)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      src_d   = src_q;
      inv_d   = inv_q;
      out_d   = out_q;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE) && !bus.clear;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      src_q   <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      src_q   <= src_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: vector table, random vs. matrix model, and control corner cases.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mix_columns_seq_if bus();

  mix_columns_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  int fwd_m [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
  int inv_m [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};

  // Carry-less product followed by polynomial long division by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'(x) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Matrix-times-column over GF(2^8) for each of the four columns.
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   acc;
    int           m;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          m   = inv ? inv_m[row][j] : fwd_m[row][j];
          acc = acc ^ gf_mul(s[127 - 8*(j + 4*c) -: 8], 8'(m));
        end
        r[127 - 8*(row + 4*c) -: 8] = acc;
      end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one transform; returns edges until done, busy-high samples and the result.
  task automatic run_xform(input logic [127:0] din, input logic inv,
                           output int edges, output int busy_cnt, output logic [127:0] res);
    bus.state_in = din;
    bus.inverse  = inv;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.state_in = {$urandom, $urandom, $urandom, $urandom};
    bus.inverse  = ~inv;
    busy_cnt = bus.busy ? 1 : 0;
    edges    = 0;
    while (!bus.done && edges < 200) begin
      step();
      edges++;
      if (bus.busy) busy_cnt++;
    end
    res = bus.state_out;
  endtask

  vec_t         tbl [4];
  logic [127:0] res, rnd, exp_v;
  logic         rinv;
  int           edges, busy_cnt, dones;

  initial begin
    tbl[0] = '{128'hDB135345_F20A225C_01010101_C6C6C6C6, 1'b0, 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6};
    tbl[1] = '{128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6, 1'b1, 128'hDB135345_F20A225C_01010101_C6C6C6C6};
    tbl[2] = '{128'hD4D4D4D5_2D26314C_01010101_C6C6C6C6, 1'b0, 128'hD5D5D7D6_4D7EBDF8_01010101_C6C6C6C6};
    tbl[3] = '{128'h00000000_FFFFFFFF_80808080_01020304, 1'b0,
               mix_ref(128'h00000000_FFFFFFFF_80808080_01020304, 1'b0)};

    bus.start = 1'b0; bus.inverse = 1'b0; bus.clear = 1'b0; bus.state_in = '0;
    #12;
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_done", 128'(bus.done), 128'd0);
    check("reset_out", bus.state_out, 128'd0);
    rst_n = 1'b1;
    step();

    // Table vectors with latency, busy width and single-cycle done.
    for (int i = 0; i < 4; i++) begin
      run_xform(tbl[i].din, tbl[i].inv, edges, busy_cnt, res);
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), 128'(edges), 128'd65);
      check($sformatf("tbl%0d_busy_cycles", i), 128'(busy_cnt), 128'd65);
      check($sformatf("tbl%0d_busy_at_done", i), 128'(bus.busy), 128'd0);
      step();
      check($sformatf("tbl%0d_done_pulse", i), 128'(bus.done), 128'd0);
      step();
      check($sformatf("tbl%0d_out_held", i), bus.state_out, tbl[i].exp);
    end

    // Random states against the matrix model.
    for (int i = 0; i < 10; i++) begin
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      rinv = 1'($urandom_range(0, 1));
      run_xform(rnd, rinv, edges, busy_cnt, res);
      check($sformatf("rand%0d_result", i), res, mix_ref(rnd, rinv));
      check($sformatf("rand%0d_latency", i), 128'(edges), 128'd65);
      step();
    end

    // Start while busy is ignored: one done, first result.
    bus.state_in = tbl[0].din; bus.inverse = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 100; e++) begin
      if (e == 20) begin bus.start = 1'b1; bus.state_in = tbl[2].din; bus.inverse = 1'b1; end
      if (e == 21) bus.start = 1'b0;
      step();
      if (bus.done) begin
        dones++;
        check("busy_start_done_edge", 128'(e), 128'd65);
        check("busy_start_result", bus.state_out, tbl[0].exp);
      end
    end
    check("busy_start_done_count", 128'(dones), 128'd1);

    // Back-to-back: restart in the cycle after done.
    run_xform(tbl[1].din, 1'b1, edges, busy_cnt, res);
    check("b2b_first_result", res, tbl[1].exp);
    step();
    run_xform(tbl[2].din, 1'b0, edges, busy_cnt, res);
    check("b2b_second_result", res, tbl[2].exp);
    check("b2b_second_latency", 128'(edges), 128'd65);
    step();

    // Clear at cnt=30: busy drops next edge, no done, then a clean restart.
    bus.state_in = tbl[0].din; bus.inverse = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (30) step();
    bus.clear = 1'b1;
    bus.start = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check("clear_busy_drop", 128'(bus.busy), 128'd0);
    dones = 0;
    for (int e = 0; e < 80; e++) begin
      step();
      if (bus.done) dones++;
      if (bus.busy) dones++;
    end
    check("clear_no_done_or_busy", 128'(dones), 128'd0);
    run_xform(tbl[0].din, 1'b0, edges, busy_cnt, res);
    check("clear_restart_result", res, tbl[0].exp);
    check("clear_restart_latency", 128'(edges), 128'd65);
    step();

    // Asynchronous reset mid-MAC.
    bus.state_in = tbl[3].din; bus.inverse = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (40) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_out", bus.state_out, 128'd0);
    #10 rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 80; e++) begin
      step();
      if (bus.done) dones++;
    end
    check("rst_no_done", 128'(dones), 128'd0);
    exp_v = tbl[3].exp;
    run_xform(tbl[3].din, 1'b0, edges, busy_cnt, res);
    check("rst_restart_result", res, exp_v);
    check("rst_restart_latency", 128'(edges), 128'd65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
